freq_div_unit: RTL and testbench

Sequential replacement for the two combinational `1_0000_0000 / freq` dividers that turn raw note frequencies into clock-divider values for note generation. It sits between the music ROM stage and `note_gen`. It applies the octave scaling and silence rule, then computes left and right quotients with one time-shared restoring divider. Both outputs update atomically and are held stable between updates.

---
 rtl/freq_div_pkg.sv | 27 ++
 rtl/serial_divider.sv | 68 ++++++
 rtl/freq_div_unit.sv | 143 ++++++++++++++
 tb/tb_freq_div_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/freq_div_pkg.sv
// Shared definitions for the note-frequency divider unit.
//   - state_t      : control FSM encoding for freq_div_unit
//   - DEF_*        : default numerator, mute code, output and numerator widths
//   - OCT_DOWN/UP  : octave select codes
//   - FREQ_W/DIV_W : raw frequency width and widened divisor width
package freq_div_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIV_L  = 2'd1,
    DIV_R  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  localparam int unsigned DEF_DIVIDEND = 100_000_000;
  localparam int unsigned DEF_SILENCE  = 100_000_000;
  localparam int unsigned DEF_QW       = 22;
  localparam int unsigned DEF_NW       = 27;

  localparam logic [2:0] OCT_DOWN = 3'd1;
  localparam logic [2:0] OCT_UP   = 3'd3;

  localparam int unsigned FREQ_W = 32;
  // Octave-up doubles the frequency, so the divisor needs one extra bit.
  localparam int unsigned DIV_W  = FREQ_W + 1;

endpackage

// File: rtl/serial_divider.sv
// Unsigned restoring divider, one quotient bit per clock, MSB first.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (control only)
//   start     : load num/divisor and begin an NW-cycle operation
//   num       : NW-bit numerator
//   divisor   : DW-bit divisor
//   done      : high during the cycle in which the final iteration executes
//   quotient  : quotient including this cycle's iteration; valid while done
// The caller captures quotient on the same edge that done is high, which
// lets a new operation be started on that edge with no idle cycle.
module serial_divider #(
  parameter int unsigned NW = 27,
  parameter int unsigned DW = 33
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW-1:0] num,
  input  logic [DW-1:0] divisor,
  output logic          done,
  output logic [NW-1:0] quotient
);

  localparam int unsigned CW = $clog2(NW + 1);

  logic [CW-1:0] cnt;
  logic [DW-1:0] rem_q;
  logic [NW-1:0] quot_q;
  logic [DW-1:0] div_q;

  logic [DW:0]   trial;
  logic          ge;
  logic [DW-1:0] rem_nxt;
  logic [NW-1:0] quot_nxt;

  // Shift the next numerator bit into the partial remainder and try a subtract.
  always_comb begin
    trial    = {rem_q, quot_q[NW-1]};
    ge       = (trial >= {1'b0, div_q});
    rem_nxt  = ge ? DW'(trial - {1'b0, div_q}) : trial[DW-1:0];
    quot_nxt = {quot_q[NW-2:0], ge};
  end

  assign done     = (cnt == CW'(1));
  assign quotient = quot_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= CW'(NW);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      rem_q  <= '0;
      quot_q <= num;
      div_q  <= divisor;
    end else if (cnt != '0) begin
      rem_q  <= rem_nxt;
      quot_q <= quot_nxt;
    end
  end

endmodule

// File: rtl/freq_div_unit.sv
// Converts raw left/right note frequencies into clock-divider values
// (DIVIDEND / freq) with octave scaling and a mute code, using a single
// serial divider shared between the two channels.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   freqL, freqR       : raw 32-bit note frequencies
//   octave             : 1 = one octave down, 3 = one octave up, else as-is
//   freq_outL/R        : registered divider values, updated together
//   upd                : one-cycle pulse after both outputs are committed
//   busy               : high while a computation is in flight
module freq_div_unit
  import freq_div_pkg::*;
#(
  parameter int unsigned DIVIDEND = DEF_DIVIDEND,
  parameter int unsigned SILENCE  = DEF_SILENCE,
  parameter int unsigned QW       = DEF_QW,
  parameter int unsigned NW       = DEF_NW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FREQ_W-1:0] freqL,
  input  logic [FREQ_W-1:0] freqR,
  input  logic [2:0]        octave,
  output logic [QW-1:0]     freq_outL,
  output logic [QW-1:0]     freq_outR,
  output logic              upd,
  output logic              busy
);

  localparam logic [NW-1:0]     NUM   = NW'(DIVIDEND);
  localparam logic [FREQ_W-1:0] MUTE  = FREQ_W'(SILENCE);
  localparam logic [NW-1:0]     MAXQ  = NW'((64'd1 << QW) - 64'd1);

  state_t            state_q, state_n;
  logic              dirty;
  logic [FREQ_W-1:0] snap_l, snap_r;
  logic [2:0]        snap_oct;
  logic [QW-1:0]     res_l, res_r;

  logic              start_cond;
  logic              div_start;
  logic [DIV_W-1:0]  div_divisor;
  logic              div_done;
  logic [NW-1:0]     div_quot;

  function automatic logic [DIV_W-1:0] eff_div(input logic [FREQ_W-1:0] f,
                                               input logic [2:0] oct);
    logic [DIV_W-1:0] d;
    if (oct == OCT_DOWN)    d = {2'b00, f[FREQ_W-1:1]};
    else if (oct == OCT_UP) d = {f, 1'b0};
    else                    d = {1'b0, f};
    return d;
  endfunction

  // Mute first, then divide-by-zero, saturation, and zero-quotient clamp.
  function automatic logic [QW-1:0] shape(input logic silent,
                                          input logic [DIV_W-1:0] d,
                                          input logic [NW-1:0] q);
    logic [QW-1:0] r;
    if (silent)          r = QW'(1);
    else if (d == '0)    r = '1;
    else if (q > MAXQ)   r = '1;
    else if (q == '0)    r = QW'(1);
    else                 r = QW'(q);
    return r;
  endfunction

  assign start_cond = dirty || ({freqL, freqR, octave} != {snap_l, snap_r, snap_oct});
  assign busy       = (state_q != IDLE);

  serial_divider #(.NW(NW), .DW(DIV_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .num      (NUM),
    .divisor  (div_divisor),
    .done     (div_done),
    .quotient (div_quot)
  );

  always_comb begin
    state_n     = state_q;
    div_start   = 1'b0;
    div_divisor = '0;
    unique case (state_q)
      IDLE: begin
        // The snapshot is latched on this same edge, so use live inputs.
        if (start_cond) begin
          div_start   = 1'b1;
          div_divisor = eff_div(freqL, octave);
          state_n     = DIV_L;
        end
      end
      DIV_L: begin
        if (div_done) begin
          div_start   = 1'b1;
          div_divisor = eff_div(snap_r, snap_oct);
          state_n     = DIV_R;
        end
      end
      DIV_R: begin
        if (div_done) state_n = COMMIT;
      end
      COMMIT: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      dirty     <= 1'b1;
      snap_l    <= '0;
      snap_r    <= '0;
      snap_oct  <= '0;
      freq_outL <= QW'(1);
      freq_outR <= QW'(1);
      upd       <= 1'b0;
    end else begin
      state_q <= state_n;
      upd     <= (state_q == COMMIT);
      if (state_q == IDLE && start_cond) begin
        snap_l   <= freqL;
        snap_r   <= freqR;
        snap_oct <= octave;
        dirty    <= 1'b0;
      end
      if (state_q == COMMIT) begin
        freq_outL <= res_l;
        freq_outR <= res_r;
      end
    end
  end

  // Per-channel results, shaped as the final quotient bit is produced.
  always_ff @(posedge clk) begin
    if (state_q == DIV_L && div_done)
      res_l <= shape(snap_l == MUTE, eff_div(snap_l, snap_oct), div_quot);
    if (state_q == DIV_R && div_done)
      res_r <= shape(snap_r == MUTE, eff_div(snap_r, snap_oct), div_quot);
  end

endmodule

// File: tb/tb_freq_div_unit.sv
module tb_freq_div_unit;

  localparam int unsigned QW       = 22;
  localparam int unsigned NW       = 27;
  localparam longint unsigned DIVIDEND = 100_000_000;
  localparam logic [31:0] SILENCE  = 32'd100_000_000;
  localparam longint unsigned MAXQ = (64'd1 << QW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   freqL, freqR;
  logic [2:0]    octave;
  logic [QW-1:0] freq_outL, freq_outR;
  logic          upd, busy;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  freq_div_unit dut (
    .clk       (clk),
    .rst       (rst),
    .freqL     (freqL),
    .freqR     (freqR),
    .octave    (octave),
    .freq_outL (freq_outL),
    .freq_outR (freq_outR),
    .upd       (upd),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Divider value a note frequency must map to.
  function automatic longint unsigned model_div(input logic [31:0] f, input logic [2:0] o);
    longint unsigned d, q;
    if (f == SILENCE) return 1;
    if (o == 3'd1)      d = longint'(f) / 2;
    else if (o == 3'd3) d = longint'(f) * 2;
    else                d = longint'(f);
    if (d == 0) return MAXQ;
    q = DIVIDEND / d;
    if (q > MAXQ) return MAXQ;
    if (q == 0) return 1;
    return q;
  endfunction

  // Reference timing: an idle unit picks up new (or first) inputs at an edge
  // and publishes both results 2*NW+1 edges later, then idles for one edge.
  int            pend;
  bit            m_dirty;
  logic [31:0]   m_l, m_r;
  logic [2:0]    m_o;
  longint unsigned exp_l, exp_r;
  bit            exp_upd;

  always @(posedge clk) begin
    if (rst) begin
      pend = -1; m_dirty = 1'b1; m_l = '0; m_r = '0; m_o = '0;
      exp_l = 1; exp_r = 1; exp_upd = 1'b0;
    end else begin
      exp_upd = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          exp_l = model_div(m_l, m_o);
          exp_r = model_div(m_r, m_o);
          exp_upd = 1'b1;
          pend = -1;
        end
      end else if (m_dirty || {freqL, freqR, octave} != {m_l, m_r, m_o}) begin
        m_l = freqL; m_r = freqR; m_o = octave; m_dirty = 1'b0;
        pend = 2 * NW + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_freq_outL", {42'd0, freq_outL}, exp_l);
      check("cyc_freq_outR", {42'd0, freq_outR}, exp_r);
      check("cyc_upd", {63'd0, upd}, {63'd0, exp_upd});
      check("cyc_busy", {63'd0, busy}, {63'd0, (pend > 0)});
    end
  end

  task automatic wait_upd(output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (upd !== 1'b1 && c < 200);
  endtask

  initial begin
    int c, chg, nu, nb;
    logic [QW-1:0] hold_l, hold_r;

    // Model pinned to hand-computed divider values.
    check("model_440", model_div(32'd440, 3'd2), 227272);
    check("model_262_up", model_div(32'd262, 3'd3), 190839);
    check("model_262_down", model_div(32'd262, 3'd1), 763358);
    check("model_523", model_div(32'd523, 3'd0), 191204);
    check("model_sil", model_div(SILENCE, 3'd1), 1);
    check("model_div0", model_div(32'd1, 3'd1), 4194303);

    rst = 1'b1; freqL = 32'd440; freqR = SILENCE; octave = 3'd2;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_outL", {42'd0, freq_outL}, 1);
    check("rst_outR", {42'd0, freq_outR}, 1);
    check("rst_upd", {63'd0, upd}, 0);
    check("rst_busy", {63'd0, busy}, 0);
    rst = 1'b0;

    // First computation starts on its own after reset.
    wait_upd(c);
    check("first_lat", c, 56);
    check("first_L", {42'd0, freq_outL}, 227272);
    check("first_R", {42'd0, freq_outR}, 1);

    freqL = 32'd262; octave = 3'd3;
    wait_upd(c);
    check("oct_up_lat", c, 56);
    check("oct_up_L", {42'd0, freq_outL}, 190839);

    octave = 3'd1;
    wait_upd(c);
    check("oct_down_lat", c, 56);
    check("oct_down_L", {42'd0, freq_outL}, 763358);

    freqL = 32'd1; freqR = 32'd440; octave = 3'd2;
    wait_upd(c);
    check("sat_L", {42'd0, freq_outL}, 4194303);
    check("norm_R", {42'd0, freq_outR}, 227272);

    freqL = 32'd0;
    wait_upd(c);
    check("zero_L", {42'd0, freq_outL}, 4194303);

    freqL = 32'd1; octave = 3'd1;
    wait_upd(c);
    check("div0_L", {42'd0, freq_outL}, 4194303);

    freqL = 32'hFFFF_FFFF; octave = 3'd3;
    wait_upd(c);
    check("q0_L", {42'd0, freq_outL}, 1);

    // Input change while the left channel is being divided.
    freqL = 32'd440; octave = 3'd2;
    repeat (10) @(negedge clk);
    freqL = 32'd523;
    wait_upd(c);
    check("midchg_lat", c + 10, 56);
    check("midchg_first_L", {42'd0, freq_outL}, 227272);
    chg = 0;
    for (int i = 0; i < 55; i++) begin
      @(negedge clk);
      if (freq_outL !== 22'd227272 || upd !== 1'b0) chg++;
    end
    check("midchg_stable", chg, 0);
    @(negedge clk);
    check("midchg_upd2", {63'd0, upd}, 1);
    check("midchg_second_L", {42'd0, freq_outL}, 191204);

    // Reset during the right-channel pass.
    freqL = 32'd262;
    repeat (37) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_outL", {42'd0, freq_outL}, 1);
    check("abort_outR", {42'd0, freq_outR}, 1);
    check("abort_upd", {63'd0, upd}, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_upd(c);
    check("abort_restart_lat", c, 56);
    check("abort_restart_L", {42'd0, freq_outL}, 381679);
    check("abort_restart_R", {42'd0, freq_outR}, 227272);

    // Quiet period with constant inputs.
    hold_l = freq_outL; hold_r = freq_outR;
    nu = 0; nb = 0; chg = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (upd !== 1'b0) nu++;
      if (busy !== 1'b0) nb++;
      if (freq_outL !== hold_l || freq_outR !== hold_r) chg++;
    end
    check("idle_upd", nu, 0);
    check("idle_busy", nb, 0);
    check("idle_outs", chg, 0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
